acs_array: RTL and testbench
============================

# acs_array

Parametrised add-compare-select engine for the Viterbi decoder. On each trellis step it sweeps all 2^(K-1) states in segments of N_ACS states, reading predecessor path metrics from the ping-pong metric memory and branch distances from the branch-metric unit. It writes the new metrics back, emits one survivor bit per state to the traceback memory, and reports the lowest-metric state. It replaces the fixed-geometry, two-clock ACS unit and adds:
- a single clock,
- per-step metric normalisation,
- saturating arithmetic,
- a Start/Done handshake,
- a pipeline-freeze Hold.

## Interface
Parameters:
- K, 7: constraint length. S = 2^(K-1) states.
- N_ACS, 4: parallel ACS cells. Power of two, 2*N_ACS <= S.
- WD_DIST, 2: branch distance width.
- WD_METR, 8: path metric width. MAX = 2^WD_METR-1.
- Derived values (localparam):
  - NSEG = S/N_ACS
  - WD_SEG = log2(NSEG)
  - WD_STATE = K-1

Ports:
- Clock  in  1  sole clock, rising edge.
- Reset  in  1  asynchronous, active-low.
- Start  in  1  begin a trellis step. Accepted only when Busy=0.
- Init  in  1  sampled with accepted Start: first step of a codeword.
- Hold  in  1  freezes every internal register and output.
- Busy  out  1  step in progress.
- Done  out  1  one-cycle pulse at step completion.
- Segment  out  WD_SEG  segment whose Distance is requested.
- Distance  in  WD_DIST*2*N_ACS  two distances per cell, returned one cycle after Segment.
- MMReadAddress  out  WD_SEG-1  old-metric word address. A word holds 2*N_ACS metrics.
- MMPathMetric  in  WD_METR*2*N_ACS  old metrics, returned one cycle after the address.
- MMWriteAddress  out  WD_SEG  new-metric word address. A word holds N_ACS metrics.
- MMWriteEn  out  1  write strobe.
- MMMetric  out  WD_METR*N_ACS  new metrics.
- MMBlockSelect  out  1  ping-pong bank being read. The bank being written is the complement.
- Survivors  out  N_ACS  one decision bit per new state.
- SurvValid  out  1  Survivors valid. Equal to MMWriteEn.
- LowestState  out  WD_STATE  lowest-metric state of the last completed step.
- LowestMetric  out  WD_METR  its normalised metric.

## Operation
- FSM states: IDLE, RUN, DRAIN, FINISH.
  - IDLE -> RUN on Start.
  - RUN issues segments 0..NSEG-1, one per cycle.
  - DRAIN lasts 2 cycles.
  - FINISH lasts 1 cycle and returns to IDLE.
- Segment s:
  - Segment = s.
  - MMReadAddress = s mod (NSEG/2).
- Predecessors: cell i computes state j = s*N_ACS+i from predecessors p0 = 2j mod S and p1 = p0+1.
  - These are metric lanes 2i and 2i+1 of the read word.
  - Distance lanes 2i and 2i+1 apply to p0 and p1 respectively.
- Normalisation offset N:
  - Equals LowestMetric of the previous step.
  - Forced to 0 on an Init step.
- Candidate c_b = sat(m_b + d_b - N):
  - Computed in WD_METR+1 bits.
  - Clamped to MAX on overflow.
  - Clamped to 0 on underflow (cannot occur when memory contents are consistent).
- On an Init step, old metrics are forced: state 0 = 0, all other states = MAX. MMPathMetric is ignored.
- Selection:
  - new metric = min(c0, c1).
  - Survivor bit = 1 iff c1 < c0. A tie selects p0 (bit 0).
- Running minimum:
  - Tracked across the step.
  - Ties keep the lower state index.
  - At FINISH it is committed to LowestState/LowestMetric, MMBlockSelect toggles, and Done pulses.
- Start while Busy=1 is ignored.
- Start in the Done cycle is accepted; Busy=0 in that cycle.
- Hold=1: FSM, segment counter, pipeline and outputs are frozen. Write strobe and Done are held, not re-asserted. Providers must keep Distance/MMPathMetric stable for the held request.

## Timing
- Reset (asynchronous) values:
  - FSM = IDLE.
  - All outputs 0, including MMBlockSelect=0 and LowestState=0.
  - LowestMetric = 0, N = 0.
- Start sampled at edge 0:
  - Segment s presented in cycle s+1.
  - Its data is registered in cycle s+2.
  - MMMetric, MMWriteEn, Survivors are visible in cycle s+3 with MMWriteAddress = s.
- Busy is high in cycles 1..NSEG+2. Done, the LowestState update and the MMBlockSelect toggle occur in cycle NSEG+3.
- Per-step cost without Hold: NSEG+3 cycles. Back-to-back steps: NSEG+3 cycles each.
- Reset low mid-step:
  - Immediate return to IDLE.
  - In-flight writes are discarded and no Done is issued.
  - The bank is not toggled (MMBlockSelect returns to 0).

## Structure
- Shared package holds:
  - width macros (WD_DIST, WD_METR, WD_STATE),
  - the FSM state encoding,
  - the saturating add-subtract function.
- One natural sub-module is acs_cell: combinational add, normalise, saturate, compare, select. It is instantiated N_ACS times.
- The top module holds the FSM, segment counter, 2-stage pipeline, running-minimum tree and bank toggle.

## Test plan
- Reset: assert Reset=0 mid-RUN.
  - All outputs return to 0 asynchronously.
  - The next Start runs a clean step with MMBlockSelect=0.
- Init step, K=3, N_ACS=2 (S=4, NSEG=2), segment 0 Distance lanes {d3,d2,d1,d0}={1,2,0,3}:
  - MMMetric = {MAX, 3}, Survivors = 00.
  - Done at cycle 5.
  - LowestState = 0, LowestMetric = 3.
- Tie-break, equal candidates 20/20 in cell 1:
  - Survivor bit 0.
  - Two states at the minimum metric -> LowestState reports the lower index.
- Normalisation, second step after LowestMetric = 3, old metrics {10,7}, distances {1,2}:
  - Candidates {8,6} -> metric 6, survivor 1.
  - MMBlockSelect = 1 throughout the step.
- Saturation, WD_METR=8, metric 254, distance 3, N=0:
  - Candidate = 255; no wrap.
- Hold asserted for 3 cycles mid-RUN, default parameters:
  - Segment/MMWriteAddress frozen, with no duplicate or missing writes.
  - Done arrives at cycle NSEG+6 = 22.

Source files
------------

// File: rtl/acs_array_pkg.sv
// Shared definitions for the Viterbi add-compare-select engine: default widths,
// FSM encoding and the saturating add/normalise helper used by every ACS cell.
package acs_array_pkg;

  localparam int K_DEF        = 7;
  localparam int N_ACS_DEF    = 4;
  localparam int WD_DIST_DEF  = 2;
  localparam int WD_METR_DEF  = 8;
  localparam int WD_STATE_DEF = K_DEF - 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } acs_state_e;

  // m + d - n with exact arithmetic, clamped to [0, maxv].
  function automatic logic [31:0] sat_addsub(input logic [31:0] m, input logic [31:0] d,
                                             input logic [31:0] n, input logic [31:0] maxv);
    logic [32:0] sum;
    sum = {1'b0, m} + {1'b0, d};
    if (sum < {1'b0, n}) return '0;
    sum = sum - {1'b0, n};
    if (sum > {1'b0, maxv}) return maxv;
    return sum[31:0];
  endfunction

endpackage

// File: rtl/acs_array_cell.sv
// One add-compare-select butterfly half: two normalised, saturated candidates,
// the smaller one wins and a tie favours the even predecessor.
module acs_array_cell
  import acs_array_pkg::*;
#(
  parameter int WD_DIST = WD_DIST_DEF,
  parameter int WD_METR = WD_METR_DEF
) (
  input  logic [WD_METR-1:0] m0_i,
  input  logic [WD_METR-1:0] m1_i,
  input  logic [WD_DIST-1:0] d0_i,
  input  logic [WD_DIST-1:0] d1_i,
  input  logic [WD_METR-1:0] norm_i,
  output logic [WD_METR-1:0] metric_o,
  output logic               surv_o
);

  localparam logic [WD_METR-1:0] MAX = '1;

  logic [WD_METR-1:0] c0;
  logic [WD_METR-1:0] c1;

  always_comb begin
    c0       = WD_METR'(sat_addsub(32'(m0_i), 32'(d0_i), 32'(norm_i), 32'(MAX)));
    c1       = WD_METR'(sat_addsub(32'(m1_i), 32'(d1_i), 32'(norm_i), 32'(MAX)));
    surv_o   = (c1 < c0);
    metric_o = surv_o ? c1 : c0;
  end

endmodule

// File: rtl/acs_array.sv
// ACS sweep engine: walks one trellis step segment by segment, writes new metrics
// and survivors, and reports the lowest-metric state when the step completes.
module acs_array
  import acs_array_pkg::*;
#(
  parameter int K       = K_DEF,
  parameter int N_ACS   = N_ACS_DEF,
  parameter int WD_DIST = WD_DIST_DEF,
  parameter int WD_METR = WD_METR_DEF,
  localparam int S        = 2 ** (K - 1),
  localparam int NSEG     = S / N_ACS,
  localparam int WD_SEG   = $clog2(NSEG),
  localparam int WD_STATE = K - 1,
  localparam int WD_RADDR = (WD_SEG > 1) ? WD_SEG - 1 : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start_i,
  input  logic                         init_i,
  input  logic                         hold_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [WD_SEG-1:0]            segment_o,
  input  logic [WD_DIST*2*N_ACS-1:0]   distance_i,
  output logic [WD_RADDR-1:0]          mm_read_address_o,
  input  logic [WD_METR*2*N_ACS-1:0]   mm_path_metric_i,
  output logic [WD_SEG-1:0]            mm_write_address_o,
  output logic                         mm_write_en_o,
  output logic [WD_METR*N_ACS-1:0]     mm_metric_o,
  output logic                         mm_block_select_o,
  output logic [N_ACS-1:0]             survivors_o,
  output logic                         surv_valid_o,
  output logic [WD_STATE-1:0]          lowest_state_o,
  output logic [WD_METR-1:0]           lowest_metric_o,
  output acs_state_e                   state_o
);

  localparam logic [WD_METR-1:0] MAX       = '1;
  localparam logic [WD_SEG-1:0]  LAST_SEG  = WD_SEG'(NSEG - 1);
  localparam logic [WD_SEG-1:0]  HALF_MASK = WD_SEG'(NSEG / 2 - 1);

  acs_state_e            state_q, state_d;
  logic [WD_SEG-1:0]     seg_q, seg_d;
  logic                  drain_q, drain_d;
  logic                  accept, enter_finish;
  logic                  init_q;
  logic [WD_METR-1:0]    norm_q;
  logic                  v1_q;
  logic [WD_SEG-1:0]     seg1_q;
  logic                  wr_en_q;
  logic [WD_SEG-1:0]     wr_addr_q;
  logic [WD_METR*N_ACS-1:0] metric_q, metric_pack;
  logic [N_ACS-1:0]      surv_q, cell_surv;
  logic [WD_METR-1:0]    cell_metric [N_ACS];
  logic [WD_METR-1:0]    min_metric_q, seg_min_metric;
  logic [WD_STATE-1:0]   min_state_q, seg_min_state;
  logic [WD_STATE-1:0]   lowest_state_q;
  logic [WD_METR-1:0]    lowest_metric_q;
  logic                  bank_q;
  logic                  p0_zero;

  // start_i is taken only when busy_o=0 (IDLE or the Done cycle); hold_i=1 freezes
  // every register so requests and strobes stay presented until hold_i drops.
  always_comb begin
    state_d      = state_q;
    seg_d        = seg_q;
    drain_d      = drain_q;
    accept       = 1'b0;
    enter_finish = 1'b0;
    case (state_q)
      ST_IDLE: if (start_i) begin
        accept  = 1'b1;
        state_d = ST_RUN;
        seg_d   = '0;
      end
      ST_RUN: begin
        seg_d = seg_q + 1'b1;
        if (seg_q == LAST_SEG) begin
          state_d = ST_DRAIN;
          drain_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) begin
          state_d      = ST_FINISH;
          enter_finish = 1'b1;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        if (start_i) begin
          accept  = 1'b1;
          state_d = ST_RUN;
          seg_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Only state 0 starts at metric 0 on an Init step; it lives in lane 0 of word 0.
  assign p0_zero = ((seg1_q & HALF_MASK) == '0);

  for (genvar gi = 0; gi < N_ACS; gi++) begin : g_cell
    logic [WD_METR-1:0] m0, m1;
    assign m0 = init_q ? (((gi == 0) && p0_zero) ? '0 : MAX)
                       : mm_path_metric_i[(2*gi)*WD_METR +: WD_METR];
    assign m1 = init_q ? MAX : mm_path_metric_i[(2*gi+1)*WD_METR +: WD_METR];

    acs_array_cell #(.WD_DIST(WD_DIST), .WD_METR(WD_METR)) u_cell (
      .m0_i     (m0),
      .m1_i     (m1),
      .d0_i     (distance_i[(2*gi)*WD_DIST +: WD_DIST]),
      .d1_i     (distance_i[(2*gi+1)*WD_DIST +: WD_DIST]),
      .norm_i   (norm_q),
      .metric_o (cell_metric[gi]),
      .surv_o   (cell_surv[gi])
    );
  end

  // Strict less-than in ascending state order keeps the lowest index on ties.
  always_comb begin
    seg_min_metric = min_metric_q;
    seg_min_state  = min_state_q;
    metric_pack    = '0;
    for (int i = 0; i < N_ACS; i++) begin
      metric_pack[i*WD_METR +: WD_METR] = cell_metric[i];
      if (cell_metric[i] < seg_min_metric) begin
        seg_min_metric = cell_metric[i];
        seg_min_state  = WD_STATE'(seg1_q) * WD_STATE'(N_ACS) + WD_STATE'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      seg_q           <= '0;
      drain_q         <= 1'b0;
      init_q          <= 1'b0;
      norm_q          <= '0;
      v1_q            <= 1'b0;
      seg1_q          <= '0;
      wr_en_q         <= 1'b0;
      wr_addr_q       <= '0;
      metric_q        <= '0;
      surv_q          <= '0;
      min_metric_q    <= '0;
      min_state_q     <= '0;
      lowest_state_q  <= '0;
      lowest_metric_q <= '0;
      bank_q          <= 1'b0;
    end else if (!hold_i) begin
      state_q <= state_d;
      seg_q   <= seg_d;
      drain_q <= drain_d;
      if (accept) begin
        init_q       <= init_i;
        norm_q       <= init_i ? '0 : lowest_metric_q;
        min_metric_q <= MAX;
        min_state_q  <= '0;
      end
      v1_q    <= (state_q == ST_RUN);
      seg1_q  <= seg_q;
      wr_en_q <= v1_q;
      if (v1_q) begin
        wr_addr_q    <= seg1_q;
        metric_q     <= metric_pack;
        surv_q       <= cell_surv;
        min_metric_q <= seg_min_metric;
        min_state_q  <= seg_min_state;
      end
      if (enter_finish) begin
        lowest_state_q  <= min_state_q;
        lowest_metric_q <= min_metric_q;
        bank_q          <= ~bank_q;
      end
    end
  end

  assign busy_o             = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done_o             = (state_q == ST_FINISH);
  assign segment_o          = seg_q;
  assign mm_read_address_o  = WD_RADDR'(seg_q & HALF_MASK);
  assign mm_write_address_o = wr_addr_q;
  assign mm_write_en_o      = wr_en_q;
  assign mm_metric_o        = metric_q;
  assign mm_block_select_o  = bank_q;
  assign survivors_o        = surv_q;
  assign surv_valid_o       = wr_en_q;
  assign lowest_state_o     = lowest_state_q;
  assign lowest_metric_o    = lowest_metric_q;
  assign state_o            = state_q;

endmodule

// File: tb/tb_acs_array.sv
// Bench for acs_array: a K=3/N_ACS=2 instance for the arithmetic corner cases and a
// default-parameter instance for the Hold timing, both checked through expected queues.
module tb_acs_array;
  import acs_array_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- small instance (K=3, N_ACS=2) ----------------
  logic        start_s, init_s, hold_s, busy_s, done_s, wen_s, blk_s, sv_s;
  logic [0:0]  seg_s, raddr_s, waddr_s;
  logic [7:0]  dist_s;
  logic [31:0] pm_s;
  logic [15:0] met_s;
  logic [1:0]  surv_s, lst_s;
  logic [7:0]  lm_s;
  acs_state_e  st_s;

  acs_array #(.K(3), .N_ACS(2), .WD_DIST(2), .WD_METR(8)) dut_s (
    .clk(clk), .rst_n(rst_n), .start_i(start_s), .init_i(init_s), .hold_i(hold_s),
    .busy_o(busy_s), .done_o(done_s), .segment_o(seg_s), .distance_i(dist_s),
    .mm_read_address_o(raddr_s), .mm_path_metric_i(pm_s), .mm_write_address_o(waddr_s),
    .mm_write_en_o(wen_s), .mm_metric_o(met_s), .mm_block_select_o(blk_s),
    .survivors_o(surv_s), .surv_valid_o(sv_s), .lowest_state_o(lst_s),
    .lowest_metric_o(lm_s), .state_o(st_s)
  );

  // ---------------- default instance ----------------
  logic        start_d, init_d, hold_d, busy_d, done_d, wen_d, blk_d, sv_d;
  logic [3:0]  seg_d, waddr_d;
  logic [2:0]  raddr_d;
  logic [15:0] dist_d;
  logic [63:0] pm_d;
  logic [31:0] met_d;
  logic [3:0]  surv_d;
  logic [5:0]  lst_d;
  logic [7:0]  lm_d;
  acs_state_e  st_d;

  acs_array dut_d (
    .clk(clk), .rst_n(rst_n), .start_i(start_d), .init_i(init_d), .hold_i(hold_d),
    .busy_o(busy_d), .done_o(done_d), .segment_o(seg_d), .distance_i(dist_d),
    .mm_read_address_o(raddr_d), .mm_path_metric_i(pm_d), .mm_write_address_o(waddr_d),
    .mm_write_en_o(wen_d), .mm_metric_o(met_d), .mm_block_select_o(blk_d),
    .survivors_o(surv_d), .surv_valid_o(sv_d), .lowest_state_o(lst_d),
    .lowest_metric_o(lm_d), .state_o(st_d)
  );

  // ---------------- providers (one-cycle response) ----------------
  logic [7:0]  dist_tab [2];
  logic [31:0] pm_word;

  always @(posedge clk) begin
    if (!hold_s) begin
      dist_s <= dist_tab[seg_s];
      pm_s   <= pm_word;
    end
  end

  assign dist_d = '0;
  assign pm_d   = '0;

  // ---------------- scoreboard ----------------
  logic [20:0] exp_wr_s   [$];  // {sv, bank, addr, metric[15:0], surv[1:0]}
  logic [18:0] exp_done_s [$];  // {lowest_state, lowest_metric, bank_after, cycle}
  logic [41:0] exp_wr_d   [$];  // {sv, bank, addr[3:0], metric[31:0], surv[3:0]}
  logic [22:0] exp_done_d [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  int tick_s = 0, start_tick_s = 0;
  always @(negedge clk) begin
    tick_s++;
    if (rst_n) begin
      if (start_s && !busy_s && !hold_s) start_tick_s = tick_s;
      if (wen_s && !hold_s) begin
        if (exp_wr_s.size() == 0) begin
          checks++; errors++;
          $display("FAIL small_write: unexpected write addr=%0d, none expected", waddr_s);
        end else
          check("small_write", 64'({sv_s, blk_s, waddr_s, met_s, surv_s}), 64'(exp_wr_s.pop_front()));
      end
      if (done_s && !hold_s) begin
        if (exp_done_s.size() == 0) begin
          checks++; errors++;
          $display("FAIL small_done: unexpected Done, none expected");
        end else
          check("small_done", 64'({lst_s, lm_s, blk_s, 8'(tick_s - start_tick_s)}), 64'(exp_done_s.pop_front()));
      end
    end
  end

  int tick_d = 0, start_tick_d = 0;
  always @(negedge clk) begin
    tick_d++;
    if (rst_n) begin
      if (start_d && !busy_d && !hold_d) start_tick_d = tick_d;
      if (wen_d && !hold_d) begin
        if (exp_wr_d.size() == 0) begin
          checks++; errors++;
          $display("FAIL dflt_write: unexpected write addr=%0d, none expected", waddr_d);
        end else
          check("dflt_write", 64'({sv_d, blk_d, waddr_d, met_d, surv_d}), 64'(exp_wr_d.pop_front()));
      end
      if (done_d && !hold_d) begin
        if (exp_done_d.size() == 0) begin
          checks++; errors++;
          $display("FAIL dflt_done: unexpected Done, none expected");
        end else
          check("dflt_done", 64'({lst_d, lm_d, blk_d, 8'(tick_d - start_tick_d)}), 64'(exp_done_d.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_step_s(input logic bank, input logic [15:0] m0, input logic [1:0] sv0,
                             input logic [15:0] m1, input logic [1:0] sv1,
                             input logic [1:0] ls, input logic [7:0] lm, input logic bank_after);
    exp_wr_s.push_back({1'b1, bank, 1'b0, m0, sv0});
    exp_wr_s.push_back({1'b1, bank, 1'b1, m1, sv1});
    exp_done_s.push_back({ls, lm, bank_after, 8'd5});
  endtask

  task automatic start_step_s(input logic init);
    @(posedge clk); #2;
    start_s = 1'b1; init_s = init;
    @(posedge clk); #2;
    start_s = 1'b0; init_s = 1'b0;
  endtask

  task automatic start_step_d(input logic init);
    @(posedge clk); #2;
    start_d = 1'b1; init_d = init;
    @(posedge clk); #2;
    start_d = 1'b0; init_d = 1'b0;
  endtask

  task automatic wait_done_s();
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (done_s) return;
    end
    checks++; errors++;
    $display("FAIL small_timeout: no Done within 60 cycles");
  endtask

  task automatic wait_done_d();
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (done_d && !hold_d) return;
    end
    checks++; errors++;
    $display("FAIL dflt_timeout: no Done within 80 cycles");
  endtask

  task automatic check_reset_s(input string tag);
    check({tag, "_busy"},  64'(busy_s),  64'd0);
    check({tag, "_done"},  64'(done_s),  64'd0);
    check({tag, "_seg"},   64'(seg_s),   64'd0);
    check({tag, "_raddr"}, 64'(raddr_s), 64'd0);
    check({tag, "_wen"},   64'({wen_s, sv_s, waddr_s}), 64'd0);
    check({tag, "_met"},   64'({met_s, surv_s}), 64'd0);
    check({tag, "_bank"},  64'(blk_s),   64'd0);
    check({tag, "_lst"},   64'(lst_s),   64'd0);
    check({tag, "_lm"},    64'(lm_s),    64'd0);
    check({tag, "_state"}, 64'(st_s),    64'(ST_IDLE));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    start_s = 0; init_s = 0; hold_s = 0;
    start_d = 0; init_d = 0; hold_d = 0;
    dist_tab[0] = '0; dist_tab[1] = '0; pm_word = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #10;
    check_reset_s("rst0");
    check("rst0_dflt", 64'({busy_d, done_d, wen_d, blk_d, lst_d, lm_d}), 64'd0);
    @(posedge clk); #2 rst_n = 1'b1;

    // Init step: lanes {d3,d2,d1,d0}={1,2,0,3}; old metrics ignored.
    dist_tab[0] = 8'h63; dist_tab[1] = 8'h07; pm_word = 32'hDEADBEEF;
    push_step_s(1'b0, 16'hFF03, 2'b00, 16'hFF03, 2'b00, 2'd0, 8'd3, 1'b1);
    start_step_s(1'b1);
    wait_done_s();

    // Normalised step, N=3: cell0 {10,7}+{1,2} -> 6/surv1, cell1 20/20 tie -> surv0.
    dist_tab[0] = 8'hE9; dist_tab[1] = 8'h08; pm_word = 32'h1415070A;
    push_step_s(1'b1, 16'h1406, 2'b01, 16'h1106, 2'b11, 2'd0, 8'd6, 1'b0);
    start_step_s(1'b0);
    wait_done_s();

    // Init again: normalisation offset must be forced to 0 despite LowestMetric=6.
    dist_tab[0] = 8'h63; dist_tab[1] = 8'h07;
    push_step_s(1'b0, 16'hFF03, 2'b00, 16'hFF03, 2'b00, 2'd0, 8'd3, 1'b1);
    start_step_s(1'b1);
    wait_done_s();

    // Reset in the middle of RUN: asynchronous clear, no writes, no Done.
    start_step_s(1'b1);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    check_reset_s("rst_mid");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Clean step after reset, N=0: 254+3 saturates at 255, lowest is state 3 at 50.
    dist_tab[0] = 8'h93; dist_tab[1] = 8'h00; pm_word = 32'h3264FFFE;
    push_step_s(1'b0, 16'h34FF, 2'b10, 16'h32FE, 2'b10, 2'd3, 8'd50, 1'b1);
    start_step_s(1'b0);
    wait_done_s();

    // Default parameters, Init step with zero distances, Hold for 3 cycles mid-RUN.
    for (int s = 0; s < 16; s++) begin
      logic [7:0] lane0;
      lane0 = (s == 0 || s == 8) ? 8'h00 : 8'hFF;
      exp_wr_d.push_back({1'b1, 1'b0, 4'(s), {24'hFFFFFF, lane0}, 4'b0000});
    end
    exp_done_d.push_back({6'd0, 8'd0, 1'b1, 8'd22});
    start_step_d(1'b1);
    repeat (4) @(posedge clk);
    #2 hold_d = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("hold_seg",   64'(seg_d),   64'd4);
      check("hold_waddr", 64'(waddr_d), 64'd2);
    end
    @(posedge clk); #2 hold_d = 1'b0;
    wait_done_d();

    repeat (3) @(posedge clk);
    check("left_wr_s",   64'(exp_wr_s.size()),   64'd0);
    check("left_done_s", 64'(exp_done_s.size()), 64'd0);
    check("left_wr_d",   64'(exp_wr_d.size()),   64'd0);
    check("left_done_d", 64'(exp_done_d.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
